cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Run-control sequencer for the VeriRISC core. Owns the 3-bit instruction phase consumed by the opcode/phase decode controller and produces the clock-enable `cpu_en` that gates every architectural register (PC, IR, AC). Adds run/step/halt debug control, a single PC breakpoint and a retired-instruction counter. Sits between the debug port and the core's control unit.

## Interface
- `PHASE_WIDTH`, 3, phase width; the phase sequence is 0..7.
- `ADDR_WIDTH`, 5, PC / breakpoint address width.
- `CNT_WIDTH`, 16, retired-instruction counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run_cmd`  in  1  one-cycle pulse: free-run.
- `step_cmd`  in  1  one-cycle pulse: execute to the next instruction boundary.
- `halt_cmd`  in  1  one-cycle pulse: debug halt request.
- `halt`  in  1  HLT decode from the controller, valid in phase 4.
- `pc_addr`  in  ADDR_WIDTH  current PC value.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  ADDR_WIDTH  breakpoint address.
- `phase`  out  PHASE_WIDTH  current phase, registered.
- `cpu_en`  out  1  datapath register enable.
- `state`  out  2  IDLE=0, RUN=1, STEP=2, HALTED=3.
- `bp_hit`  out  1  sticky; set when the core stops on the breakpoint.
- `instr_count`  out  CNT_WIDTH  retired instructions; saturates.

## Operation
- Reset values: state IDLE, phase 0, cpu_en 0, bp_hit 0, instr_count 0, halt-pending flag 0.
- `cpu_en` = 1 in RUN or STEP, otherwise 0. `phase` advances (7 wraps to 0) only on an edge where cpu_en=1 and no halt is taken on that edge.
- IDLE: run_cmd -> RUN. step_cmd -> STEP. If both arrive together, run wins. halt_cmd is ignored.
- RUN: halt_cmd sets the pending flag. On the boundary edge (phase==7, cpu_en=1):
  - If pending is set, or if bp_en and pc_addr==bp_addr: go to HALTED, phase wraps to 0.
  - In the breakpoint case only, bp_hit is also set.
  - Otherwise stay in RUN.
- STEP: on the boundary edge, go to HALTED with phase 0. Breakpoint and pending flag are not evaluated.
- HLT (RUN or STEP): halt=1 with phase==4 and cpu_en=1 -> HALTED on that edge. Phase stays 4 (not advanced). The instruction counts as retired.
- HALTED: run_cmd -> RUN, step_cmd -> STEP (run wins if both). Execution resumes from the held phase. Entering RUN or STEP clears bp_hit.
- Pending flag is cleared on every entry to HALTED. halt_cmd is ignored in IDLE and HALTED.
- run_cmd in RUN and step_cmd in STEP are ignored. run_cmd in STEP -> RUN, with the phase continuing.
- instr_count increments by 1 on each boundary edge with cpu_en=1 and on each HLT halt edge. It holds at all-ones. Only rst clears it.

## Timing
- Commands are sampled on the edge. A command at edge k changes state at edge k. cpu_en is high during cycle k+1, and phase first advances at edge k+1.
- A halt_cmd sampled in the same cycle as phase 7 in RUN takes effect on that same boundary edge.
- Debug halt/breakpoint latency: at most 8 cycles from halt_cmd to HALTED.
- A step started from HALTED at phase 0 takes exactly 8 enabled cycles (phases 0..7).
- `rst` asserted mid-instruction forces all outputs to reset values immediately, with no wait for a clock edge.

## Structure
- Shared package `veririsc_pkg`:
  - state encoding constants;
  - PH_HLT=4, PH_LAST=7;
  - opcode constants shared with the controller.
- One sub-module, `phase_counter`: PHASE_WIDTH-bit wrap counter with enable and hold, reset to 0.
- The FSM, pending flag, breakpoint compare and saturating counter live in `cpu_sequencer`.

## Test plan
- Reset then run_cmd with halt=0 for 24 cycles:
  - phase goes 0..7 three times;
  - instr_count=3;
  - cpu_en high throughout.
- step_cmd from IDLE:
  - cpu_en high for exactly 8 cycles;
  - then HALTED, phase 0, instr_count=1.
- RUN with halt=1 at phase 4 of the second instruction:
  - HALTED, phase 4, instr_count=2, cpu_en 0.
  - run_cmd then resumes at phase 5.
- bp_en=1, bp_addr=5; pc_addr reaches 5 at a boundary in RUN:
  - HALTED, phase 0, bp_hit=1.
  - run_cmd then clears bp_hit.
- halt_cmd at phase 2 in RUN:
  - halts after the phase-7 edge, state=3.
  - A repeat with halt_cmd exactly at phase 7 halts on that same edge.
- rst mid-RUN at phase 5 with instr_count=9:
  - IDLE, phase 0, count 0 before the next clock edge.
- Separately, CNT_WIDTH=2: count stops at 3 after 4+ instructions.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: sequencer state encoding, phase markers, opcodes.
package veririsc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    // Phase in which the controller presents the HLT decode.
    localparam int PH_HLT  = 4;
    // Last phase of an instruction; the edge leaving it is the instruction boundary.
    localparam int PH_LAST = 7;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

endpackage

// File: rtl/phase_counter.sv
// Instruction phase counter: wraps through 0..2**WIDTH-1 while enabled, holds otherwise.
module phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] phase
);

    // Advance on enabled edges; natural overflow provides the wrap to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase <= '0;
        else if (en)
            phase <= phase + WIDTH'(1);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Run-control sequencer for the VeriRISC core: phase generation, datapath enable,
// run/step/halt debug control, PC breakpoint and retired-instruction counter.
//
//   state  | meaning
//   IDLE   | out of reset, core not started
//   RUN    | free-running, stops on debug halt, breakpoint or HLT
//   STEP   | runs to the next instruction boundary (or HLT), then halts
//   HALTED | stopped; phase held so execution resumes where it left off
module cpu_sequencer
    import veririsc_pkg::*;
#(
    parameter int PHASE_WIDTH = 3,
    parameter int ADDR_WIDTH  = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_cmd,
    input  logic                   step_cmd,
    input  logic                   halt_cmd,
    input  logic                   halt,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    input  logic                   bp_en,
    input  logic [ADDR_WIDTH-1:0]  bp_addr,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   cpu_en,
    output logic [1:0]             state,
    output logic                   bp_hit,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    seq_state_t cur_state, nxt_state;
    logic       pending, pending_nxt;
    logic       bp_hit_nxt;
    logic       boundary, hlt_take, bp_match, advance;

    assign cpu_en   = (cur_state == ST_RUN) || (cur_state == ST_STEP);
    assign boundary = cpu_en && (phase == PHASE_WIDTH'(PH_LAST));
    assign hlt_take = cpu_en && halt && (phase == PHASE_WIDTH'(PH_HLT));
    assign bp_match = bp_en && (pc_addr == bp_addr);
    // An HLT freezes the phase at 4; a boundary halt still wraps 7 -> 0.
    assign advance  = cpu_en && !hlt_take;
    assign state    = cur_state;

    phase_counter #(.WIDTH(PHASE_WIDTH)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .en    (advance),
        .phase (phase)
    );

    // Next-state, pending-halt and breakpoint-flag decode.
    always_comb begin
        nxt_state   = cur_state;
        pending_nxt = pending;
        bp_hit_nxt  = bp_hit;
        case (cur_state)
            ST_IDLE: begin
                if (run_cmd)       nxt_state = ST_RUN;
                else if (step_cmd) nxt_state = ST_STEP;
            end
            ST_RUN: begin
                if (hlt_take) begin
                    nxt_state = ST_HALTED;
                end else if (boundary && (pending || halt_cmd || bp_match)) begin
                    nxt_state = ST_HALTED;
                    if (bp_match) bp_hit_nxt = 1'b1;
                end else if (halt_cmd) begin
                    pending_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                if (hlt_take || boundary) nxt_state = ST_HALTED;
                else if (run_cmd)         nxt_state = ST_RUN;
            end
            ST_HALTED: begin
                if (run_cmd)       nxt_state = ST_RUN;
                else if (step_cmd) nxt_state = ST_STEP;
                if (run_cmd || step_cmd) bp_hit_nxt = 1'b0;
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (nxt_state == ST_HALTED && cur_state != ST_HALTED)
            pending_nxt = 1'b0;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_IDLE;
            pending   <= 1'b0;
            bp_hit    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            pending   <= pending_nxt;
            bp_hit    <= bp_hit_nxt;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr_count <= '0;
        else if ((boundary || hlt_take) && (instr_count != '1))
            instr_count <= instr_count + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed test-plan sequences plus random
// command traffic, checked every cycle against a behavioural model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_cmd = 1'b0, step_cmd = 1'b0, halt_cmd = 1'b0, halt = 1'b0;
    logic [4:0]  pc_addr = '0, bp_addr = '0;
    logic        bp_en = 1'b0;

    logic [2:0]  phase, s_phase;
    logic        cpu_en, s_cpu_en, bp_hit, s_bp_hit;
    logic [1:0]  state, s_state;
    logic [15:0] instr_count;
    logic [1:0]  s_count;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run_cmd(run_cmd), .step_cmd(step_cmd),
        .halt_cmd(halt_cmd), .halt(halt), .pc_addr(pc_addr), .bp_en(bp_en),
        .bp_addr(bp_addr), .phase(phase), .cpu_en(cpu_en), .state(state),
        .bp_hit(bp_hit), .instr_count(instr_count)
    );

    cpu_sequencer #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .run_cmd(run_cmd), .step_cmd(step_cmd),
        .halt_cmd(halt_cmd), .halt(halt), .pc_addr(pc_addr), .bp_en(bp_en),
        .bp_addr(bp_addr), .phase(s_phase), .cpu_en(s_cpu_en), .state(s_state),
        .bp_hit(s_bp_hit), .instr_count(s_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int ph;
        int en;
        int hit;
        int c16;
        int c2;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: named modes, phase as an integer 0..7, unbounded count.
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;
    int m_mode, m_phase, m_retired;
    bit m_pending, m_hit;

    bit         pc_be = 1'b0;
    logic [4:0] pc_v = '0, ba_v = '0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_phase = 0; m_retired = 0; m_pending = 0; m_hit = 0;
    endtask

    task automatic model_step(input bit rc, input bit sc, input bit hc, input bit hl,
                              input int pc, input bit be, input int ba);
        bit executing, finishing, hlt_now, stop;
        int next_mode;
        executing = (m_mode == M_RUN) || (m_mode == M_STEP);
        finishing = executing && (m_phase == 7);
        hlt_now   = executing && hl && (m_phase == 4);
        stop      = 0;
        next_mode = m_mode;
        if (m_mode == M_IDLE || m_mode == M_HALTED) begin
            if (rc || sc) begin
                next_mode = rc ? M_RUN : M_STEP;
                if (m_mode == M_HALTED) m_hit = 0;
            end
        end else if (hlt_now) begin
            stop = 1;
        end else if (m_mode == M_STEP) begin
            if (finishing) stop = 1;
            else if (rc) next_mode = M_RUN;
        end else begin
            if (finishing && (m_pending || hc || (be && pc == ba))) begin
                stop = 1;
                if (be && pc == ba) m_hit = 1;
            end else if (hc) begin
                m_pending = 1;
            end
        end
        if (stop) begin
            next_mode = M_HALTED;
            m_pending = 0;
        end
        if (finishing || hlt_now) m_retired++;
        if (executing && !hlt_now) m_phase = (m_phase + 1) % 8;
        m_mode = next_mode;
    endtask

    task automatic cycle(input bit rc, input bit sc, input bit hc, input bit hl);
        exp_t e;
        @(negedge clk);
        run_cmd = rc; step_cmd = sc; halt_cmd = hc; halt = hl;
        pc_addr = pc_v; bp_en = pc_be; bp_addr = ba_v;
        model_step(rc, sc, hc, hl, int'(pc_v), pc_be, int'(ba_v));
        e.st  = m_mode;
        e.ph  = m_phase;
        e.en  = (m_mode == M_RUN || m_mode == M_STEP) ? 1 : 0;
        e.hit = m_hit ? 1 : 0;
        e.c16 = (m_retired > 65535) ? 65535 : m_retired;
        e.c2  = (m_retired > 3) ? 3 : m_retired;
        q.push_back(e);
        @(posedge clk);
    endtask

    // Reset asserted mid-cycle; outputs are optionally checked before any edge.
    task automatic do_reset(input bit check_now);
        @(negedge clk);
        #2;
        rst = 1'b1;
        run_cmd = 0; step_cmd = 0; halt_cmd = 0; halt = 0;
        #1;
        if (check_now) begin
            chk("rst_state", int'(state), 0);
            chk("rst_phase", int'(phase), 0);
            chk("rst_cpu_en", int'(cpu_en), 0);
            chk("rst_bp_hit", int'(bp_hit), 0);
            chk("rst_count", int'(instr_count), 0);
            chk("rst_small_count", int'(s_count), 0);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare both instances against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", int'(state), e.st);
                chk("phase", int'(phase), e.ph);
                chk("cpu_en", int'(cpu_en), e.en);
                chk("bp_hit", int'(bp_hit), e.hit);
                chk("instr_count", int'(instr_count), e.c16);
                chk("small_count", int'(s_count), e.c2);
                chk("small_phase", int'(s_phase), e.ph);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        do_reset(1);

        // Free run for three instructions.
        cycle(1, 0, 0, 0);
        repeat (24) cycle(0, 0, 0, 0);
        #1;
        chk("run24_count", int'(instr_count), 3);
        chk("run24_cpu_en", int'(cpu_en), 1);
        chk("run24_phase", int'(phase), 0);

        // Single step from IDLE.
        do_reset(0);
        cycle(0, 1, 0, 0);
        repeat (8) cycle(0, 0, 0, 0);
        #1;
        chk("step_state", int'(state), 3);
        chk("step_phase", int'(phase), 0);
        chk("step_count", int'(instr_count), 1);

        // HLT in phase 4 of the second instruction, then resume.
        do_reset(0);
        cycle(1, 0, 0, 0);
        repeat (12) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        #1;
        chk("hlt_state", int'(state), 3);
        chk("hlt_phase", int'(phase), 4);
        chk("hlt_count", int'(instr_count), 2);
        chk("hlt_cpu_en", int'(cpu_en), 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        #1;
        chk("resume_phase", int'(phase), 5);

        // Breakpoint at address 5 on the second boundary.
        do_reset(0);
        pc_be = 1; ba_v = 5; pc_v = 3;
        cycle(1, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 0);
        pc_v = 5;
        repeat (8) cycle(0, 0, 0, 0);
        #1;
        chk("bp_state", int'(state), 3);
        chk("bp_phase", int'(phase), 0);
        chk("bp_hit_set", int'(bp_hit), 1);
        cycle(1, 0, 0, 0);
        #1;
        chk("bp_hit_clear", int'(bp_hit), 0);
        pc_be = 0;

        // Debug halt at phase 2, then exactly at phase 7.
        do_reset(0);
        cycle(1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 0);
        #1;
        chk("pend_still_run", int'(state), 1);
        cycle(0, 0, 0, 0);
        #1;
        chk("pend_halted", int'(state), 3);
        chk("pend_phase", int'(phase), 0);
        do_reset(0);
        cycle(1, 0, 0, 0);
        repeat (7) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        #1;
        chk("halt7_state", int'(state), 3);

        // Async reset mid-instruction with nine retired; small counter saturated.
        do_reset(0);
        cycle(1, 0, 0, 0);
        repeat (77) cycle(0, 0, 0, 0);
        #1;
        chk("pre_rst_phase", int'(phase), 5);
        chk("pre_rst_count", int'(instr_count), 9);
        chk("small_saturated", int'(s_count), 3);
        do_reset(1);

        // Random command traffic.
        repeat (3000) begin
            pc_v  = 5'($urandom_range(0, 7));
            ba_v  = 5'($urandom_range(0, 7));
            pc_be = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
